// File: rtl/pipe_arb_pkg.sv
// Shared types for the pipelined round-robin arbiter: requester ID width and
// the tag that travels alongside each issue through the shared datapath.
package pipe_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } arb_tag_t;

endpackage

// File: rtl/pipe_arbiter_tag_delay_line.sv
// Fixed-length tag shift register running in lockstep with the shared datapath.
// It never stalls; a synchronous clear invalidates every stage at once.
module tag_delay_line
  import pipe_arb_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  arb_tag_t tag,
  output arb_tag_t tail
);

  arb_tag_t stages [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) stages[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < LATENCY; k++) stages[k] <= '0;
    end else begin
      stages[0] <= tag;
      for (int k = 1; k < LATENCY; k++) stages[k] <= stages[k-1];
    end
  end

  assign tail = stages[LATENCY-1];

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency datapath among NUM_REQ requesters,
// routing each result back by ID tag. Optional occupancy counter: PIPE_ARB_OCCUPANCY_EN.
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  input  logic                            flush_in,
  output logic                            pipe_valid_out,
  output logic [DATA_W-1:0]               pipe_data_out,
  input  logic [DATA_W-1:0]               pipe_result_in,
  output logic [NUM_REQ-1:0]              resp_valid_out,
  output logic [DATA_W-1:0]               resp_data_out
`ifdef PIPE_ARB_OCCUPANCY_EN
  ,
  output logic [$clog2(LATENCY+2)-1:0]    occupancy_out
`endif
);

  if (NUM_REQ > MAX_REQ || NUM_REQ < 2) begin : g_bad_num_req
    $error("pipe_arbiter: NUM_REQ must be within 2..MAX_REQ");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("pipe_arbiter: LATENCY must be at least 1");
  end

  req_id_t            rr_ptr;
  req_id_t            grant_id;
  req_id_t            next_ptr;
  req_id_t            issue_id;
  logic               accept;
  logic               found;
  logic [DATA_W-1:0]  sel_data;
  arb_tag_t           issue_tag;
  arb_tag_t           last_tag;

  // Search from rr_ptr upward with wrap; a flush cycle grants nobody.
  always_comb begin
    req_ready_out = '0;
    grant_id      = '0;
    found         = 1'b0;
    if (!flush_in) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!found && req_valid_in[j] && ((int'(rr_ptr) + k) % NUM_REQ == j)) begin
            req_ready_out[j] = 1'b1;
            grant_id         = req_id_t'(j);
            found            = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_ready_out[j]) sel_data = req_data_in[j];
    end
  end

  assign accept   = |(req_valid_in & req_ready_out);
  assign next_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : req_id_t'(int'(grant_id) + 1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr         <= '0;
      pipe_valid_out <= 1'b0;
      pipe_data_out  <= '0;
      issue_id       <= '0;
    end else begin
      pipe_valid_out <= accept;
      if (accept) begin
        pipe_data_out <= sel_data;
        issue_id      <= grant_id;
        rr_ptr        <= next_ptr;
      end
    end
  end

  // The tag enters the chain alongside the issue strobe, so its tail lines up with the result.
  assign issue_tag = '{valid: pipe_valid_out, id: issue_id};

  tag_delay_line #(
    .LATENCY (LATENCY)
  ) u_tags (
    .clk   (clk_in),
    .rst   (rst_in),
    .clear (flush_in),
    .tag   (issue_tag),
    .tail  (last_tag)
  );

  always_comb begin
    resp_valid_out = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (last_tag.valid && int'(last_tag.id) == j) resp_valid_out[j] = 1'b1;
    end
  end

  assign resp_data_out = pipe_result_in;

`ifdef PIPE_ARB_OCCUPANCY_EN
  localparam int OCC_W = $clog2(LATENCY + 2);

  logic [OCC_W-1:0] occ_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      occ_cnt <= '0;
    end else if (flush_in) begin
      occ_cnt <= '0;
    end else if (accept && !last_tag.valid) begin
      occ_cnt <= occ_cnt + OCC_W'(1);
    end else if (!accept && last_tag.valid) begin
      occ_cnt <= occ_cnt - OCC_W'(1);
    end
  end

  assign occupancy_out = occ_cnt;
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter; the datapath is modelled as a 3-deep delay
// with result = operand ^ 16'h5A5A.
module tb_pipe_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int LATENCY = 3;

  logic                           clk = 1'b0;
  logic                           rst = 1'b1;
  logic [NUM_REQ-1:0]             req_valid = '0;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           flush = 1'b0;
  logic                           pipe_valid;
  logic [DATA_W-1:0]              pipe_data;
  logic [DATA_W-1:0]              pipe_result;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [DATA_W-1:0]              resp_data;
`ifdef PIPE_ARB_OCCUPANCY_EN
  logic [$clog2(LATENCY+2)-1:0]   occupancy;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] dl [LATENCY];
  logic [DATA_W-1:0] exp_res [4] = '{16'h5B5A, 16'h585A, 16'h595A, 16'h5E5A};
  logic [NUM_REQ-1:0] exp_vec;
  logic [DATA_W-1:0]  exp_word;

  pipe_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .req_valid_in   (req_valid),
    .req_data_in    (req_data),
    .req_ready_out  (req_ready),
    .flush_in       (flush),
    .pipe_valid_out (pipe_valid),
    .pipe_data_out  (pipe_data),
    .pipe_result_in (pipe_result),
    .resp_valid_out (resp_valid),
    .resp_data_out  (resp_data)
`ifdef PIPE_ARB_OCCUPANCY_EN
    ,
    .occupancy_out  (occupancy)
`endif
  );

  always #5 clk = ~clk;

  // Shared datapath stand-in: fixed LATENCY-cycle delay with a visible transform.
  always @(posedge clk) begin
    dl[0] <= pipe_data;
    for (int k = 1; k < LATENCY; k++) dl[k] <= dl[k-1];
  end
  assign pipe_result = dl[LATENCY-1] ^ 16'h5A5A;

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      vectors++;
      if (pipe_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_pipe_valid: got %b expected 0", pipe_valid);
      end
      vectors++;
      if (resp_valid !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL reset_resp_valid: got %b expected 0000", resp_valid);
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL reset_first_grant: got %b expected 0001", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_data[2] = 16'h00A5;
      req_valid   = (c == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0) begin
        vectors++;
        if (req_ready !== 4'b0100) begin
          miscompares++;
          $display("[TB] FAIL single_grant: got %b expected 0100", req_ready);
        end
      end
      if (c == 1) begin
        vectors++;
        if (pipe_valid !== 1'b1 || pipe_data !== 16'h00A5) begin
          miscompares++;
          $display("[TB] FAIL single_issue: got valid %b data %h expected 1 00a5", pipe_valid, pipe_data);
        end
      end
      if (c >= 2) begin
        exp_vec = (c == 4) ? 4'b0100 : 4'b0000;
        vectors++;
        if (resp_valid !== exp_vec) begin
          miscompares++;
          $display("[TB] FAIL single_resp_c%0d: got %b expected %b", c, resp_valid, exp_vec);
        end
      end
      if (c == 4) begin
        vectors++;
        if (resp_data !== 16'h5AFF) begin
          miscompares++;
          $display("[TB] FAIL single_resp_data: got %h expected 5aff", resp_data);
        end
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    req_valid = 4'b1011;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL wrap_ptr3_pick3: got %b expected 1000", req_ready);
    end
    req_valid   = 4'b0010;
    req_data[1] = 16'h1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL wrap_skip_to_1: got %b expected 0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL wrap_next_ptr2: got %b expected 0100", req_ready);
    end
    req_valid = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_contention();
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) req_data[i] = DATA_W'(16'h0100 * (i + 1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        exp_vec = 4'(1 << (c % 4));
        vectors++;
        if (req_ready !== exp_vec) begin
          miscompares++;
          $display("[TB] FAIL contention_grant_c%0d: got %b expected %b", c, req_ready, exp_vec);
        end
      end
      if (c >= 1 && c <= 8) begin
        exp_word = DATA_W'(16'h0100 * (((c - 1) % 4) + 1));
        vectors++;
        if (pipe_valid !== 1'b1 || pipe_data !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL contention_issue_c%0d: got %b %h expected 1 %h", c, pipe_valid, pipe_data, exp_word);
        end
      end
      exp_vec = (c >= 4 && c <= 11) ? 4'(1 << ((c - 4) % 4)) : 4'b0000;
      vectors++;
      if (resp_valid !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL contention_resp_c%0d: got %b expected %b", c, resp_valid, exp_vec);
      end
      if (c >= 4 && c <= 11) begin
        exp_word = exp_res[(c - 4) % 4];
        vectors++;
        if (resp_data !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL contention_data_c%0d: got %h expected %h", c, resp_data, exp_word);
        end
      end
    end
  endtask

  task automatic test_flush();
    req_data[3] = 16'hBEEF;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      case (c)
        0:       req_valid = 4'b0001;
        1:       req_valid = 4'b0010;
        2:       req_valid = 4'b0100;
        3:       req_valid = 4'b0001;
        10:      req_valid = 4'b1000;
        default: req_valid = 4'b0000;
      endcase
      flush = (c == 3);
      #1;
      if (c == 3) begin
        vectors++;
        if (req_ready !== 4'b0000) begin
          miscompares++;
          $display("[TB] FAIL flush_grant_suppressed: got %b expected 0000", req_ready);
        end
      end
      if (c == 4) begin
        vectors++;
        if (pipe_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL flush_no_issue: got %b expected 0", pipe_valid);
        end
      end
      if (c >= 4 && c <= 9) begin
        vectors++;
        if (resp_valid !== 4'b0000) begin
          miscompares++;
          $display("[TB] FAIL flush_no_resp_c%0d: got %b expected 0000", c, resp_valid);
        end
      end
      if (c == 10) begin
        vectors++;
        if (req_ready !== 4'b1000) begin
          miscompares++;
          $display("[TB] FAIL flush_post_grant: got %b expected 1000", req_ready);
        end
      end
      if (c == 14) begin
        vectors++;
        if (resp_valid !== 4'b1000 || resp_data !== 16'hE4B5) begin
          miscompares++;
          $display("[TB] FAIL flush_post_resp: got %b %h expected 1000 e4b5", resp_valid, resp_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_valid   = (c < 5) ? 4'b0010 : 4'b0000;
      req_data[1] = DATA_W'(16'h1000 + c);
      #1;
      if (c < 5) begin
        vectors++;
        if (req_ready !== 4'b0010) begin
          miscompares++;
          $display("[TB] FAIL b2b_grant_c%0d: got %b expected 0010", c, req_ready);
        end
      end
      if (c >= 1 && c <= 5) begin
        exp_word = DATA_W'(16'h1000 + c - 1);
        vectors++;
        if (pipe_valid !== 1'b1 || pipe_data !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL b2b_issue_c%0d: got %b %h expected 1 %h", c, pipe_valid, pipe_data, exp_word);
        end
      end
      if (c >= 4) begin
        exp_word = DATA_W'(16'h1000 + c - 4) ^ 16'h5A5A;
        vectors++;
        if (resp_valid !== 4'b0010 || resp_data !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL b2b_resp_c%0d: got %b %h expected 0010 %h", c, resp_valid, resp_data, exp_word);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid = (c == 0) ? 4'b0001 : 4'b0010;
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    vectors++;
    if (pipe_valid !== 1'b0 || resp_valid !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_clear: got %b %b expected 0 0000", pipe_valid, resp_valid);
    end
`ifdef PIPE_ARB_OCCUPANCY_EN
    vectors++;
    if (occupancy !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_occupancy: got %0d expected 0", occupancy);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL midreset_ptr: got %b expected 0001", req_ready);
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      vectors++;
      if (resp_valid !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL midreset_no_resp_c%0d: got %b expected 0000", c, resp_valid);
      end
    end
  endtask

`ifdef PIPE_ARB_OCCUPANCY_EN
  task automatic test_occupancy();
    int exp_occ [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    req_data[2] = 16'h0042;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = (c < 3) ? 4'b0100 : 4'b0000;
      #1;
      vectors++;
      if (int'(occupancy) !== exp_occ[c]) begin
        miscompares++;
        $display("[TB] FAIL occupancy_c%0d: got %0d expected %0d", c, occupancy, exp_occ[c]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_flush();
    test_back_to_back();
    test_reset_midflight();
`ifdef PIPE_ARB_OCCUPANCY_EN
    test_occupancy();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
